lsu_mmio: RTL and testbench

- Load/store unit downstream of the single-cycle core's ALU.
- Consumes the computed effective address, the rs2 store data and the store enable. Returns formatted load data for register writeback.
- Owns the data memory and the memory-mapped I/O registers that drive the LEDs, HEX displays and LCD, and samples the switches and buttons.
- Single-outstanding valid/ready request with a one-cycle registered response.

---
 rtl/lsu_mmio.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu_mmio.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mmio.sv
// Load/store unit: 2 KiB data memory plus memory-mapped LED/HEX/LCD registers
// and synchronised switch/button inputs, behind a single-outstanding request port.
module lsu_mmio #(
  parameter int DMEM_AW     = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wren,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_rsp_vld,
  output logic [31:0] o_ld_data,
  output logic        o_err,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);
  localparam int DMEM_WORDS = 2 ** (DMEM_AW - 2);
  localparam logic [31:0] ADDR_LEDR  = 32'h1000_0000;
  localparam logic [31:0] ADDR_LEDG  = 32'h1000_1000;
  localparam logic [31:0] ADDR_HEXLO = 32'h1000_2000;
  localparam logic [31:0] ADDR_HEXHI = 32'h1000_3000;
  localparam logic [31:0] ADDR_LCD   = 32'h1000_4000;
  localparam logic [31:0] ADDR_SW    = 32'h1001_0000;
  localparam logic [31:0] ADDR_BTN   = 32'h1001_1000;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_reg;
  logic        rsp_vld_reg, err_reg, zero_reg, dmem_sel_reg, uns_reg;
  logic [1:0]  size_reg, off_reg;
  logic [31:0] io_rdata_reg;
  logic [31:0] ledr_reg, ledg_reg, lcd_reg;
  logic [31:0] sw_sync [SYNC_STAGES];
  logic [3:0]  btn_sync [SYNC_STAGES];
  logic [6:0]  hex_val [8];
  logic [31:0] dmem_rdata;

  logic        accept, misalign, wr_en;
  logic        hit_dmem, hit_ledr, hit_ledg, hit_hex_lo, hit_hex_hi, hit_lcd, hit_sw, hit_btn;
  logic [3:0]  be;
  logic [31:0] wdata_lanes, io_rdata, raw, shifted, fmt;
  logic [DMEM_AW-3:0] word_idx;

  assign o_req_rdy = (state_reg == IDLE) && !i_rst;
  assign accept    = i_req_vld && o_req_rdy;
  assign word_idx  = i_addr[DMEM_AW-1:2];

  assign hit_dmem   = (i_addr[31:DMEM_AW] == '0);
  assign hit_ledr   = (i_addr[31:2] == ADDR_LEDR[31:2]);
  assign hit_ledg   = (i_addr[31:2] == ADDR_LEDG[31:2]);
  assign hit_hex_lo = (i_addr[31:2] == ADDR_HEXLO[31:2]);
  assign hit_hex_hi = (i_addr[31:2] == ADDR_HEXHI[31:2]);
  assign hit_lcd    = (i_addr[31:2] == ADDR_LCD[31:2]);
  assign hit_sw     = (i_addr[31:2] == ADDR_SW[31:2]);
  assign hit_btn    = (i_addr[31:2] == ADDR_BTN[31:2]);

  // Store data is replicated across lanes so each byte enable picks the right slice.
  always_comb begin
    misalign    = 1'b0;
    be          = 4'b0000;
    wdata_lanes = i_wdata;
    case (i_size)
      2'b00: begin
        be          = 4'b0001 << i_addr[1:0];
        wdata_lanes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        misalign    = i_addr[0];
        be          = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        misalign = |i_addr[1:0];
        be       = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  assign wr_en = accept && i_wren && !misalign;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DMEM_WORDS];
    logic [7:0] rd_reg;
    always_ff @(posedge i_clk) begin
      if (wr_en && hit_dmem && be[gi]) mem[word_idx] <= wdata_lanes[8*gi +: 8];
      if (accept) rd_reg <= mem[word_idx];
    end
    assign dmem_rdata[8*gi +: 8] = rd_reg;
  end

  for (gi = 0; gi < 8; gi++) begin : g_hex
    logic [6:0] digit_reg;
    logic       hit;
    assign hit = (gi < 4) ? hit_hex_lo : hit_hex_hi;
    always_ff @(posedge i_clk) begin
      if (i_rst) digit_reg <= '0;
      else if (wr_en && hit && be[gi % 4]) digit_reg <= wdata_lanes[8*(gi % 4) +: 7];
    end
    assign hex_val[gi] = digit_reg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_reg <= '0;
      ledg_reg <= '0;
      lcd_reg  <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (hit_ledr) ledr_reg[8*b +: 8] <= wdata_lanes[8*b +: 8];
          if (hit_ledg) ledg_reg[8*b +: 8] <= wdata_lanes[8*b +: 8];
          if (hit_lcd)  lcd_reg[8*b +: 8]  <= wdata_lanes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sw_sync[s]  <= '0;
        btn_sync[s] <= '0;
      end
    end else begin
      sw_sync[0]  <= i_io_sw;
      btn_sync[0] <= i_io_btn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sw_sync[s]  <= sw_sync[s-1];
        btn_sync[s] <= btn_sync[s-1];
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    if (hit_ledr)   io_rdata = ledr_reg;
    if (hit_ledg)   io_rdata = ledg_reg;
    if (hit_hex_lo) io_rdata = {1'b0, hex_val[3], 1'b0, hex_val[2], 1'b0, hex_val[1], 1'b0, hex_val[0]};
    if (hit_hex_hi) io_rdata = {1'b0, hex_val[7], 1'b0, hex_val[6], 1'b0, hex_val[5], 1'b0, hex_val[4]};
    if (hit_lcd)    io_rdata = lcd_reg;
    if (hit_sw)     io_rdata = sw_sync[SYNC_STAGES-1];
    if (hit_btn)    io_rdata = {28'd0, btn_sync[SYNC_STAGES-1]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      rsp_vld_reg  <= 1'b0;
      err_reg      <= 1'b0;
      zero_reg     <= 1'b1;
      dmem_sel_reg <= 1'b0;
      uns_reg      <= 1'b0;
      size_reg     <= 2'b00;
      off_reg      <= 2'b00;
      io_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          rsp_vld_reg <= 1'b0;
          err_reg     <= 1'b0;
          if (accept) begin
            state_reg    <= RESP;
            rsp_vld_reg  <= 1'b1;
            err_reg      <= misalign;
            zero_reg     <= i_wren || misalign;
            dmem_sel_reg <= hit_dmem;
            uns_reg      <= i_unsigned;
            size_reg     <= i_size;
            off_reg      <= i_addr[1:0];
            io_rdata_reg <= io_rdata;
          end
        end
        default: begin
          state_reg   <= IDLE;
          rsp_vld_reg <= 1'b0;
          err_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Lane extraction and extension happen after the registered read.
  always_comb begin
    raw     = dmem_sel_reg ? dmem_rdata : io_rdata_reg;
    shifted = raw >> {off_reg, 3'b000};
    case (size_reg)
      2'b00:   fmt = uns_reg ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   fmt = uns_reg ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: fmt = raw;
    endcase
  end

  assign o_rsp_vld = rsp_vld_reg && !i_rst;
  assign o_err     = err_reg && o_rsp_vld;
  assign o_ld_data = (o_rsp_vld && !zero_reg) ? fmt : 32'd0;

  assign o_io_ledr = ledr_reg;
  assign o_io_ledg = ledg_reg;
  assign o_io_lcd  = lcd_reg;
  assign o_io_hex0 = hex_val[0];
  assign o_io_hex1 = hex_val[1];
  assign o_io_hex2 = hex_val[2];
  assign o_io_hex3 = hex_val[3];
  assign o_io_hex4 = hex_val[4];
  assign o_io_hex5 = hex_val[5];
  assign o_io_hex6 = hex_val[6];
  assign o_io_hex7 = hex_val[7];
endmodule

// File: tb/tb_lsu_mmio.sv
// Bench for lsu_mmio: byte-level memory/IO model checked every cycle, directed
// literal cases from the test plan, then a randomized traffic phase with resets.
module tb_lsu_mmio;
  localparam int DMEM_AW    = 11;
  localparam int SYNC       = 2;
  localparam int DMEM_BYTES = 2 ** DMEM_AW;
  localparam logic [31:0] A_LEDR  = 32'h1000_0000;
  localparam logic [31:0] A_LEDG  = 32'h1000_1000;
  localparam logic [31:0] A_HEXLO = 32'h1000_2000;
  localparam logic [31:0] A_HEXHI = 32'h1000_3000;
  localparam logic [31:0] A_LCD   = 32'h1000_4000;
  localparam logic [31:0] A_SW    = 32'h1001_0000;
  localparam logic [31:0] A_BTN   = 32'h1001_1000;

  logic        i_clk = 1'b0, i_rst = 1'b1, i_req_vld = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        i_wren = 1'b0, i_unsigned = 1'b0;
  logic [1:0]  i_size = 2'b10;
  logic [31:0] i_io_sw = '0;
  logic [3:0]  i_io_btn = '0;
  logic        o_req_rdy, o_rsp_vld, o_err;
  logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
  logic [6:0]  hex_out [8];

  always #5 i_clk = ~i_clk;

  lsu_mmio #(.DMEM_AW(DMEM_AW), .SYNC_STAGES(SYNC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wren(i_wren), .i_size(i_size),
    .i_unsigned(i_unsigned), .o_rsp_vld(o_rsp_vld), .o_ld_data(o_ld_data), .o_err(o_err),
    .i_io_sw(i_io_sw), .i_io_btn(i_io_btn), .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
    .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2), .o_io_hex3(o_io_hex3),
    .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5), .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7),
    .o_io_lcd(o_io_lcd)
  );

  assign hex_out[0] = o_io_hex0;
  assign hex_out[1] = o_io_hex1;
  assign hex_out[2] = o_io_hex2;
  assign hex_out[3] = o_io_hex3;
  assign hex_out[4] = o_io_hex4;
  assign hex_out[5] = o_io_hex5;
  assign hex_out[6] = o_io_hex6;
  assign hex_out[7] = o_io_hex7;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [DMEM_BYTES];
  bit          mem_ok [DMEM_BYTES];
  logic [31:0] ledr_m = '0, ledg_m = '0, lcd_m = '0;
  logic [6:0]  hex_m [8];
  logic [31:0] sw_q [$];
  logic [3:0]  btn_q [$];
  bit          resp_m = 1'b0, err_m = 1'b0, ld_ok_m = 1'b1;
  logic [31:0] ld_m = '0;

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, output bit ok);
    logic [31:0] base, r;
    base = {a[31:2], 2'b00};
    r = '0;
    ok = 1'b1;
    if (a < DMEM_BYTES) begin
      for (int i = 0; i < 4; i++) begin
        r[8*i +: 8] = mem_m[base + i];
        if (!mem_ok[base + i]) ok = 1'b0;
      end
    end else if (base == A_LEDR) r = ledr_m;
    else if (base == A_LEDG) r = ledg_m;
    else if (base == A_LCD) r = lcd_m;
    else if (base == A_HEXLO) r = {1'b0, hex_m[3], 1'b0, hex_m[2], 1'b0, hex_m[1], 1'b0, hex_m[0]};
    else if (base == A_HEXHI) r = {1'b0, hex_m[7], 1'b0, hex_m[6], 1'b0, hex_m[5], 1'b0, hex_m[4]};
    else if (base == A_SW) r = sw_q[sw_q.size() - SYNC];
    else if (base == A_BTN) r = {28'd0, btn_q[btn_q.size() - SYNC]};
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns, output bit ok);
    logic [31:0] w, sh;
    w  = model_word(a, ok);
    sh = w >> (int'(a[1:0]) * 8);
    case (sz)
      2'b00:   return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    int n;
    logic [31:0] ba, base;
    logic [7:0] d;
    int lane;
    n = 1 << sz;
    base = {a[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      d = wd[8*i +: 8];
      lane = int'(ba[1:0]);
      if (a < DMEM_BYTES) begin
        mem_m[ba] = d;
        mem_ok[ba] = 1'b1;
      end else if (base == A_LEDR) ledr_m[8*lane +: 8] = d;
      else if (base == A_LEDG) ledg_m[8*lane +: 8] = d;
      else if (base == A_LCD) lcd_m[8*lane +: 8] = d;
      else if (base == A_HEXLO) hex_m[lane] = d[6:0];
      else if (base == A_HEXHI) hex_m[4 + lane] = d[6:0];
    end
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) begin
      sw_q.push_back('0);
      btn_q.push_back('0);
    end
    for (int i = 0; i < 8; i++) hex_m[i] = '0;
    for (int i = 0; i < DMEM_BYTES; i++) mem_ok[i] = 1'b0;
  end

  always @(posedge i_clk) begin
    bit ok;
    if (i_rst) begin
      resp_m = 1'b0; err_m = 1'b0; ld_m = '0; ld_ok_m = 1'b1;
      ledr_m = '0; ledg_m = '0; lcd_m = '0;
      for (int i = 0; i < 8; i++) hex_m[i] = '0;
      sw_q.push_back('0);
      btn_q.push_back('0);
    end else begin
      if (!resp_m && i_req_vld) begin
        ld_ok_m = 1'b1;
        ld_m = '0;
        err_m = is_bad(i_addr, i_size);
        if (!err_m) begin
          if (i_wren) model_store(i_addr, i_wdata, i_size);
          else begin
            ld_m = model_load(i_addr, i_size, i_unsigned, ok);
            ld_ok_m = ok;
          end
        end
        $display("txn addr=%h we=%0d size=%0d uns=%0d -> ld=%h err=%0d",
                 i_addr, i_wren, i_size, i_unsigned, ld_m, err_m);
        resp_m = 1'b1;
      end else resp_m = 1'b0;
      sw_q.push_back(i_io_sw);
      btn_q.push_back(i_io_btn);
    end
    while (sw_q.size() > 8) void'(sw_q.pop_front());
    while (btn_q.size() > 8) void'(btn_q.pop_front());
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin
    bit rv;
    if (check_en) begin
      rv = !i_rst && resp_m;
      chk("req_rdy", 32'(o_req_rdy), 32'(!i_rst && !resp_m));
      chk("rsp_vld", 32'(o_rsp_vld), 32'(rv));
      if (rv) begin
        chk("err", 32'(o_err), 32'(err_m));
        if (ld_ok_m) chk("ld_data", o_ld_data, ld_m);
      end
      if (i_rst) begin
        chk("err_in_rst", 32'(o_err), 32'd0);
        chk("ld_in_rst", o_ld_data, 32'd0);
      end
      chk("ledr", o_io_ledr, ledr_m);
      chk("ledg", o_io_ledg, ledg_m);
      chk("lcd", o_io_lcd, lcd_m);
      for (int i = 0; i < 8; i++) chk($sformatf("hex%0d", i), 32'(hex_out[i]), 32'(hex_m[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic [1:0] sz, input logic uns,
                     output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    i_addr = a; i_wdata = wd; i_wren = we; i_size = sz; i_unsigned = uns; i_req_vld = 1'b1;
    while (o_req_rdy !== 1'b1 && n < 20) begin
      @(posedge i_clk); #2;
      n++;
    end
    if (n >= 20) chk("rdy_timeout", 32'(o_req_rdy), 32'd1);
    @(posedge i_clk); #2;
    // Junk request during the response cycle must be ignored.
    i_addr = $urandom; i_wdata = $urandom; i_wren = 1'($urandom_range(0, 1));
    rd = o_ld_data;
    er = o_err;
    $display("req addr=%h we=%0d size=%0d uns=%0d -> data=%h err=%0d", a, we, sz, uns, rd, er);
    @(posedge i_clk); #2;
    i_req_vld = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] io_bases [7];
    logic [31:0] unm [5];
    io_bases = '{A_LEDR, A_LEDG, A_HEXLO, A_HEXHI, A_LCD, A_SW, A_BTN};
    unm = '{32'h0000_0800, 32'h0000_0FFC, 32'h1000_5000, 32'h2000_0000, 32'h1001_2000};
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 32'h100 + 32'($urandom_range(0, 63));
      4:          return 32'h7F0 + 32'($urandom_range(0, 15));
      5, 6:       return io_bases[$urandom_range(0, 6)] + 32'($urandom_range(0, 3));
      default:    return unm[$urandom_range(0, 4)];
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    logic er;
    bit ok;
    int sz;
    i_rst = 1'b1;
    @(posedge i_clk); #2;
    check_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #2 i_rst = 1'b0;

    for (int a = 32'h100; a < 32'h140; a += 4) req(a, $urandom, 1'b1, 2'b10, 1'b0, rd, er);
    for (int a = 32'h7F0; a < 32'h800; a += 4) req(a, $urandom, 1'b1, 2'b10, 1'b0, rd, er);

    req(32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, rd, er);
    chk("sw_rsp_data", rd, 32'd0);
    chk("model_word_100", model_word(32'h100, ok), 32'hDEADBEEF);
    req(32'h100, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("lw_100", rd, 32'hDEADBEEF);
    chk("lw_100_err", 32'(er), 32'd0);
    req(32'h103, 32'h0, 1'b0, 2'b00, 1'b0, rd, er);
    chk("lb_103", rd, 32'hFFFFFFDE);
    req(32'h103, 32'h0, 1'b0, 2'b00, 1'b1, rd, er);
    chk("lbu_103", rd, 32'h000000DE);
    req(32'h102, 32'h0, 1'b0, 2'b01, 1'b0, rd, er);
    chk("lh_102", rd, 32'hFFFFDEAD);
    req(32'h100, 32'h0, 1'b0, 2'b01, 1'b1, rd, er);
    chk("lhu_100", rd, 32'h0000BEEF);

    req(32'h1000_2001, 32'h55, 1'b1, 2'b00, 1'b0, rd, er);
    chk("hex1_sb", 32'(o_io_hex1), 32'h55);
    chk("hex0_kept", 32'(o_io_hex0), 32'h0);
    chk("hex2_kept", 32'(o_io_hex2), 32'h0);
    req(A_LEDR, 32'h12345678, 1'b1, 2'b10, 1'b0, rd, er);
    chk("ledr_sw", o_io_ledr, 32'h12345678);

    req(32'h101, 32'h0, 1'b0, 2'b01, 1'b0, rd, er);
    chk("lh_101_err", 32'(er), 32'd1);
    chk("lh_101_data", rd, 32'd0);
    req(32'h102, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("lw_102_err", 32'(er), 32'd1);
    req(32'h102, 32'h11111111, 1'b1, 2'b10, 1'b0, rd, er);
    chk("sw_102_err", 32'(er), 32'd1);
    req(32'h100, 32'h0, 1'b1, 2'b11, 1'b0, rd, er);
    chk("size11_err", 32'(er), 32'd1);
    req(32'h100, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("lw_100_unchanged", rd, 32'hDEADBEEF);
    req(A_SW, 32'hFFFFFFFF, 1'b1, 2'b10, 1'b0, rd, er);
    chk("sw_to_ro_err", 32'(er), 32'd0);

    i_io_sw = 32'hA5A5A5A5;
    i_io_btn = 4'hA;
    repeat (2) begin @(posedge i_clk); #2; end
    req(A_SW, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("lw_sw", rd, 32'hA5A5A5A5);
    req(A_BTN, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("lw_btn", rd, 32'h0000000A);
    i_io_sw = 32'h0F0F0F0F;
    req(A_SW, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("lw_sw_latency", rd, 32'hA5A5A5A5);

    req(32'h7FC, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0, rd, er);
    req(32'h7FF, 32'h0, 1'b0, 2'b00, 1'b1, rd, er);
    chk("lbu_7ff", rd, 32'h000000CA);
    req(32'h800, 32'h77777777, 1'b1, 2'b10, 1'b0, rd, er);
    req(32'h800, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("lw_unmapped", rd, 32'd0);
    chk("lw_unmapped_err", 32'(er), 32'd0);

    // Reset while a load is in its response cycle.
    i_addr = 32'h100; i_wren = 1'b0; i_size = 2'b10; i_req_vld = 1'b1;
    @(posedge i_clk); #2;
    i_req_vld = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("rst_resp_vld", 32'(o_rsp_vld), 32'd0);
    chk("rst_rdy", 32'(o_req_rdy), 32'd0);
    repeat (2) begin @(posedge i_clk); #2; end
    chk("rst_ledr", o_io_ledr, 32'd0);
    chk("rst_hex1", 32'(o_io_hex1), 32'd0);
    chk("rst_rdy_held", 32'(o_req_rdy), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(o_req_rdy), 32'd1);
    req(32'h100, 32'h0, 1'b0, 2'b10, 1'b0, rd, er);
    chk("dmem_kept_rst", rd, 32'hDEADBEEF);

    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk); #2;
      i_rst = ($urandom_range(0, 299) == 0);
      i_req_vld = ($urandom_range(0, 9) < 6);
      i_addr = pick_addr();
      i_wdata = $urandom;
      i_wren = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 7);
      i_size = (sz == 7) ? 2'b11 : 2'(sz % 3);
      i_unsigned = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) i_io_sw = $urandom;
      if ($urandom_range(0, 7) == 0) i_io_btn = 4'($urandom);
    end
    @(posedge i_clk); #2;
    i_req_vld = 1'b0;
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
